// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
//   Data-memory stage for the accumulator datapath. Holds the data RAM and a
//   three-state access FSM (IDLE -> ACCESS -> RESP) with a configurable number
//   of wait states before the array access edge. Loads return data on
//   mem_rdata, which feeds the accumulator's memory input. Stores take their
//   data from the accumulator output.
//
// Parameters
//   DATA_W       data width (matches accumulator width)
//   ADDR_W       address width
//   DEPTH        implemented words; legal addresses 0..DEPTH-1
//   WAIT_STATES  extra ACCESS cycles before the array access edge (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    access request from control
//   req_write    1 = store, 0 = load
//   req_addr     word address
//   req_wdata    store data
//   req_ready    unit is IDLE and accepts req_valid this cycle
//   stall        high whenever the unit is not IDLE (freezes the PC)
//   mem_rdata    last load result, held between loads
//   load_done    1-cycle pulse, mem_rdata is new this cycle
//   store_done   1-cycle pulse, store completed (or discarded)
//   addr_err     1-cycle pulse alongside a done pulse when addr >= DEPTH
// ---------------------------------------------------------------------------
module data_mem_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              load_done,
  output logic              store_done,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              op_write;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              access_now;
  logic              op_legal;
  logic [IDX_W-1:0]  op_idx;

  logic [DATA_W-1:0] ram [DEPTH];

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  assign req_ready  = (state == IDLE);
  assign stall      = (state != IDLE);
  assign access_now = (state == ACCESS) && (cnt == 4'd0);
  assign op_legal   = addr_legal(op_addr);
  assign op_idx     = op_addr[IDX_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter, load result and response pulses. The pulses are set on the
  // access edge so they are registered and high for exactly the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      mem_rdata  <= '0;
      load_done  <= 1'b0;
      store_done <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        cnt <= 4'(WAIT_STATES);
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access_now && !op_write) begin
        mem_rdata <= op_legal ? ram[op_idx] : '0;
      end
      load_done  <= access_now && !op_write;
      store_done <= access_now && op_write;
      addr_err   <= access_now && !op_legal;
    end
  end

  // Request capture at accept; later changes on req_* cannot reach an
  // in-flight transaction.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      op_write <= req_write;
      op_addr  <= req_addr;
      op_wdata <= req_wdata;
    end
  end

  // RAM write. A reset forces IDLE asynchronously, so an aborted store never
  // reaches this edge.
  always_ff @(posedge clk) begin
    if (access_now && op_write && op_legal) begin
      ram[op_idx] <= op_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  localparam int N = 4;

  function automatic int ws_of(input int i);
    case (i)
      0: return 0;
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int dp_of(input int i);
    return (i == 3) ? 128 : 256;
  endfunction

  bit          clk;
  logic        rst_n [N];
  logic        rv    [N];
  logic        rw    [N];
  logic [7:0]  ra    [N];
  logic [7:0]  rwd   [N];
  logic        rdy   [N];
  logic        stl   [N];
  logic [7:0]  rd    [N];
  logic        ld    [N];
  logic        sd    [N];
  logic        ae    [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_unit #(
      .DATA_W(8), .ADDR_W(8), .DEPTH(dp_of(g)), .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .req_valid(rv[g]), .req_write(rw[g]), .req_addr(ra[g]), .req_wdata(rwd[g]),
      .req_ready(rdy[g]), .stall(stl[g]), .mem_rdata(rd[g]),
      .load_done(ld[g]), .store_done(sd[g]), .addr_err(ae[g])
    );
  end

  // Transaction-level model: a request accepted at edge k completes its
  // array access at edge k+W+1 and the unit is free again after edge k+W+2.
  int         edge_n = 0;
  bit         m_busy [N];
  int         m_acc  [N];
  bit         m_w    [N];
  logic [7:0] m_a    [N];
  logic [7:0] m_d    [N];
  logic [7:0] m_rd   [N];
  bit         m_rdk  [N];
  logic [7:0] mram   [N][256];
  bit         mknown [N][256];

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    for (int i = 0; i < N; i++) begin
      if (rst_n[i] !== 1'b1) begin
        m_busy[i] = 0;
        m_rd[i]   = 8'h00;
        m_rdk[i]  = 1;
      end else if (m_busy[i]) begin
        if (edge_n == m_acc[i] + ws_of(i) + 1) begin
          if (m_w[i]) begin
            if (int'(m_a[i]) < dp_of(i)) begin
              mram[i][m_a[i]]   = m_d[i];
              mknown[i][m_a[i]] = 1;
            end
          end else if (int'(m_a[i]) < dp_of(i)) begin
            m_rd[i]  = mram[i][m_a[i]];
            m_rdk[i] = mknown[i][m_a[i]];
          end else begin
            m_rd[i]  = 8'h00;
            m_rdk[i] = 1;
          end
        end else if (edge_n == m_acc[i] + ws_of(i) + 2) begin
          m_busy[i] = 0;
        end
      end else if (rv[i] === 1'b1) begin
        m_busy[i] = 1;
        m_acc[i]  = edge_n;
        m_w[i]    = rw[i];
        m_a[i]    = ra[i];
        m_d[i]    = rwd[i];
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cmp_all();
    bit at;
    bit e_rdy, e_stl, e_ld, e_sd, e_ae, e_rdk;
    logic [7:0] e_rd;
    for (int i = 0; i < N; i++) begin
      if (rst_n[i] !== 1'b1) begin
        e_rdy = 1; e_stl = 0; e_ld = 0; e_sd = 0; e_ae = 0; e_rd = 8'h00; e_rdk = 1;
      end else begin
        at    = m_busy[i] && (edge_n == m_acc[i] + ws_of(i) + 1);
        e_stl = m_busy[i];
        e_rdy = !m_busy[i];
        e_ld  = at && !m_w[i];
        e_sd  = at && m_w[i];
        e_ae  = at && !(int'(m_a[i]) < dp_of(i));
        e_rd  = m_rd[i];
        e_rdk = m_rdk[i];
      end
      chk($sformatf("u%0d_req_ready", i), 32'(rdy[i]), 32'(e_rdy));
      chk($sformatf("u%0d_stall", i), 32'(stl[i]), 32'(e_stl));
      chk($sformatf("u%0d_load_done", i), 32'(ld[i]), 32'(e_ld));
      chk($sformatf("u%0d_store_done", i), 32'(sd[i]), 32'(e_sd));
      chk($sformatf("u%0d_addr_err", i), 32'(ae[i]), 32'(e_ae));
      if (e_rdk) chk($sformatf("u%0d_mem_rdata", i), 32'(rd[i]), 32'(e_rd));
    end
  endtask

  // Issue one request on instance i (which must be idle) and wait for its done pulse.
  task automatic txn(input int i, input bit w, input logic [7:0] a, input logic [7:0] d,
                     output int lat, output logic [7:0] rdat, output logic err);
    bit got;
    got  = 0;
    lat  = -1;
    rdat = 8'hxx;
    err  = 1'bx;
    @(negedge clk);
    rv[i] = 1; rw[i] = w; ra[i] = a; rwd[i] = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) rv[i] = 0;
      if (ld[i] === 1'b1 || sd[i] === 1'b1) begin
        got = 1; lat = n; rdat = rd[i]; err = ae[i];
        break;
      end
    end
    chk($sformatf("u%0d_done_seen", i), 32'(got), 32'd1);
  endtask

  int         lat;
  logic [7:0] rdat;
  logic       err;
  int         cnt_a, cnt_b;

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 0; rv[i] = 0; rw[i] = 0; ra[i] = 8'h00; rwd[i] = 8'h00;
    end
    fork
      forever begin
        @(negedge clk);
        cmp_all();
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(rdy[0]), 32'd1);
    chk("rst_stall", 32'(stl[0]), 32'd0);
    chk("rst_mem_rdata", 32'(rd[0]), 32'h00);
    chk("rst_pulses", {29'd0, ld[0], sd[0], ae[0]}, 32'd0);
    #1;
    for (int i = 0; i < N; i++) rst_n[i] = 1;

    // W=0 store then load
    txn(0, 1, 8'h10, 8'h5A, lat, rdat, err);
    chk("w0_store_latency", 32'(lat), 32'd2);
    chk("w0_store_err", 32'(err), 32'd0);
    txn(0, 0, 8'h10, 8'h00, lat, rdat, err);
    chk("w0_load_latency", 32'(lat), 32'd2);
    chk("w0_load_data", 32'(rdat), 32'h5A);
    @(negedge clk);
    chk("w0_load_held", 32'(rd[0]), 32'h5A);
    chk("w0_no_repeat_pulse", 32'(ld[0]), 32'd0);

    // W=2 back-to-back loads with req_valid held high
    txn(1, 1, 8'h07, 8'h42, lat, rdat, err);
    chk("w2_store_latency", 32'(lat), 32'd4);
    @(negedge clk);
    rv[1] = 1; rw[1] = 0; ra[1] = 8'h07;
    cnt_a = 0; cnt_b = 0;
    repeat (20) begin
      @(negedge clk);
      cnt_a += int'(ld[1]);
      cnt_b += int'(stl[1]);
    end
    rv[1] = 0;
    chk("w2_load_done_count", 32'(cnt_a), 32'd4);
    chk("w2_stall_cycles", 32'(cnt_b), 32'd16);
    chk("w2_load_data", 32'(rd[1]), 32'h42);
    repeat (3) @(negedge clk);

    // DEPTH=128 illegal address handling (W=1)
    txn(3, 1, 8'h00, 8'h77, lat, rdat, err);
    chk("d128_store0_err", 32'(err), 32'd0);
    txn(3, 1, 8'h80, 8'hFF, lat, rdat, err);
    chk("d128_bad_store_latency", 32'(lat), 32'd3);
    chk("d128_bad_store_err", 32'(err), 32'd1);
    txn(3, 0, 8'h00, 8'h00, lat, rdat, err);
    chk("d128_load0_data", 32'(rdat), 32'h77);
    chk("d128_load0_err", 32'(err), 32'd0);
    txn(3, 0, 8'h80, 8'h00, lat, rdat, err);
    chk("d128_bad_load_data", 32'(rdat), 32'h00);
    chk("d128_bad_load_err", 32'(err), 32'd1);

    // W=3 reset during ACCESS aborts a store
    txn(2, 1, 8'h05, 8'h11, lat, rdat, err);
    chk("w3_store_latency", 32'(lat), 32'd5);
    @(negedge clk);
    rv[2] = 1; rw[2] = 1; ra[2] = 8'h05; rwd[2] = 8'h33;
    @(negedge clk);
    rv[2] = 0;
    @(negedge clk);
    chk("w3_busy_before_abort", 32'(stl[2]), 32'd1);
    #1 rst_n[2] = 0;
    #1;
    chk("w3_abort_ready", 32'(rdy[2]), 32'd1);
    chk("w3_abort_stall", 32'(stl[2]), 32'd0);
    cnt_a = 0;
    repeat (2) begin @(negedge clk); cnt_a += int'(sd[2]); end
    #1 rst_n[2] = 1;
    repeat (6) begin @(negedge clk); cnt_a += int'(sd[2]); end
    chk("w3_no_store_done", 32'(cnt_a), 32'd0);
    chk("w3_rdata_cleared", 32'(rd[2]), 32'h00);
    txn(2, 0, 8'h05, 8'h00, lat, rdat, err);
    chk("w3_reload_data", 32'(rdat), 32'h11);

    // Request while busy is ignored
    txn(0, 1, 8'h01, 8'hA1, lat, rdat, err);
    txn(0, 1, 8'h02, 8'hB2, lat, rdat, err);
    @(negedge clk);
    rv[0] = 1; rw[0] = 0; ra[0] = 8'h01;
    @(negedge clk);
    rv[0] = 1; rw[0] = 1; ra[0] = 8'h02; rwd[0] = 8'hEE;
    @(negedge clk);
    rv[0] = 0;
    chk("busy_load_done", 32'(ld[0]), 32'd1);
    chk("busy_load_data", 32'(rd[0]), 32'hA1);
    cnt_a = 0;
    repeat (6) begin @(negedge clk); cnt_a += int'(ld[0]) + int'(sd[0]); end
    chk("busy_no_extra_done", 32'(cnt_a), 32'd0);
    txn(0, 0, 8'h02, 8'h00, lat, rdat, err);
    chk("busy_ram_unchanged", 32'(rdat), 32'hB2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
